regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (RegWrite/RD/WriteData) between two writeback requesters: ALU path (A) and load/memory path (M).
- Each requester has a small input queue with valid/ready handshake. Queued writes are drained one per cycle under round-robin arbitration.
- The winning write is presented on a registered output stage that drives the register file directly.
- Also reports drain status and a saturating conflict counter for performance debug.

---
 rtl/regfile_wb_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// and load writeback paths, each fronted by a small circular queue.

module regfile_wb_queue #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2,
    parameter int CQ_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_rd,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [CQ_W-1:0]   o_count,
    output logic [ADDR_W-1:0] o_head_rd,
    output logic [DATA_W-1:0] o_head_data
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] r_mem_rd   [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [PTR_W-1:0]  r_wp;
    logic [PTR_W-1:0]  r_rp;
    logic [CQ_W-1:0]   r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wp <= r_wp + PTR_W'(1);
            end
            if (i_pop) begin
                r_rp <= r_rp + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CQ_W'(1);
                2'b01:   r_count <= r_count - CQ_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem_rd[r_wp]   <= i_rd;
            r_mem_data[r_wp] <= i_data;
        end
    end

    assign o_count     = r_count;
    assign o_head_rd   = r_mem_rd[r_rp];
    assign o_head_data = r_mem_data[r_rp];
endmodule

module regfile_wb_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              m_valid,
    input  logic [ADDR_W-1:0] m_rd,
    input  logic [DATA_W-1:0] m_data,
    output logic              m_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_rd,
    output logic [DATA_W-1:0] wr_data,
    output logic              idle,
    output logic [CNT_W-1:0]  conflicts
);
    localparam int CQ_W = $clog2(DEPTH + 1);

    logic [CQ_W-1:0]   w_a_count;
    logic [CQ_W-1:0]   w_m_count;
    logic [ADDR_W-1:0] w_a_head_rd;
    logic [ADDR_W-1:0] w_m_head_rd;
    logic [DATA_W-1:0] w_a_head_data;
    logic [DATA_W-1:0] w_m_head_data;
    logic              w_a_push;
    logic              w_m_push;
    logic              w_a_ne;
    logic              w_m_ne;
    logic              w_grant_a;
    logic              w_grant_m;
    logic              w_conflict;
    logic [ADDR_W-1:0] w_sel_rd;
    logic [DATA_W-1:0] w_sel_data;
    logic              r_last_m;
    logic [CNT_W-1:0]  r_conflicts;

    // Ready comes from registered occupancy only: a full queue stays closed
    // even in a cycle where it is being drained.
    assign a_ready  = !reset && (w_a_count < CQ_W'(DEPTH));
    assign m_ready  = !reset && (w_m_count < CQ_W'(DEPTH));
    assign w_a_push = a_valid && a_ready;
    assign w_m_push = m_valid && m_ready;
    assign w_a_ne   = (w_a_count != '0);
    assign w_m_ne   = (w_m_count != '0);

    regfile_wb_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CQ_W(CQ_W)) u_queue_a (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_a_push),
        .i_rd        (a_rd),
        .i_data      (a_data),
        .i_pop       (w_grant_a),
        .o_count     (w_a_count),
        .o_head_rd   (w_a_head_rd),
        .o_head_data (w_a_head_data)
    );

    regfile_wb_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CQ_W(CQ_W)) u_queue_m (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_m_push),
        .i_rd        (m_rd),
        .i_data      (m_data),
        .i_pop       (w_grant_m),
        .o_count     (w_m_count),
        .o_head_rd   (w_m_head_rd),
        .o_head_data (w_m_head_data)
    );

    // Round-robin grant: on contention the side that did not win last time wins.
    always_comb begin
        w_grant_a  = 1'b0;
        w_grant_m  = 1'b0;
        w_conflict = 1'b0;
        if (w_a_ne && w_m_ne) begin
            w_conflict = 1'b1;
            if (r_last_m) begin
                w_grant_a = 1'b1;
            end else begin
                w_grant_m = 1'b1;
            end
        end else if (w_a_ne) begin
            w_grant_a = 1'b1;
        end else if (w_m_ne) begin
            w_grant_m = 1'b1;
        end else begin
            w_grant_a = 1'b0;
            w_grant_m = 1'b0;
        end
    end

    assign w_sel_rd   = w_grant_m ? w_m_head_rd   : w_a_head_rd;
    assign w_sel_data = w_grant_m ? w_m_head_data : w_a_head_data;

    // Output stage; writes to x0 consume their slot but never assert wr_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_rd   <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= (w_grant_a || w_grant_m) && (w_sel_rd != '0);
            if (w_grant_a || w_grant_m) begin
                wr_rd   <= w_sel_rd;
                wr_data <= w_sel_data;
            end
        end
    end

    // Last-grant pointer starts at M so A wins the first conflict.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_m <= 1'b1;
        end else if (w_grant_a) begin
            r_last_m <= 1'b0;
        end else if (w_grant_m) begin
            r_last_m <= 1'b1;
        end
    end

    // Saturating contention counter for performance debug.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_conflicts <= '0;
        end else if (w_conflict && !(&r_conflicts)) begin
            r_conflicts <= r_conflicts + CNT_W'(1);
        end
    end

    assign conflicts = r_conflicts;
    assign idle      = (w_a_count == '0) && (w_m_count == '0) && !wr_en;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised bench for regfile_wb_arbiter: a queue-based reference model
// predicts each register-file write and a monitor checks them as they appear.

module tb_regfile_wb_arbiter;
    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int DEPTH    = 2;
    localparam int CNT_W    = 2;
    localparam int CONF_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } ent_t;

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              a_valid;
    logic [ADDR_W-1:0] a_rd;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              m_valid;
    logic [ADDR_W-1:0] m_rd;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_rd;
    logic [DATA_W-1:0] wr_data;
    logic              idle;
    logic [CNT_W-1:0]  conflicts;

    int tests = 0;
    int fails = 0;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_rd      (a_rd),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .m_valid   (m_valid),
        .m_rd      (m_rd),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .wr_en     (wr_en),
        .wr_rd     (wr_rd),
        .wr_data   (wr_data),
        .idle      (idle),
        .conflicts (conflicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    ent_t qa[$];
    ent_t qm[$];
    exp_t sb[$];
    int   cyc    = 0;
    bit   armed  = 1'b0;
    bit   last_m = 1'b1;
    int   mconf  = 0;
    bit   mwr_en = 1'b0;
    bit   mod_a_rdy;
    bit   mod_m_rdy;
    int   gsel;
    ent_t ge;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: at each edge, arbitrate on pre-edge occupancy, then accept pushes.
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            qa.delete();
            qm.delete();
            sb.delete();
            last_m = 1'b1;
            mconf  = 0;
            mwr_en = 1'b0;
            armed  = 1'b1;
        end else begin
            mod_a_rdy = (qa.size() < DEPTH);
            mod_m_rdy = (qm.size() < DEPTH);
            gsel = 0;
            if (qa.size() > 0 && qm.size() > 0) begin
                gsel = last_m ? 1 : 2;
                if (mconf < CONF_MAX) mconf++;
            end else if (qa.size() > 0) begin
                gsel = 1;
            end else if (qm.size() > 0) begin
                gsel = 2;
            end
            mwr_en = 1'b0;
            if (gsel != 0) begin
                if (gsel == 1) ge = qa.pop_front();
                else           ge = qm.pop_front();
                last_m = (gsel == 2);
                if (ge.rd != 0) begin
                    sb.push_back('{cyc, ge.rd, ge.data});
                    mwr_en = 1'b1;
                end
            end
            if (a_valid && mod_a_rdy) qa.push_back('{a_rd, a_data});
            if (m_valid && mod_m_rdy) qm.push_back('{m_rd, m_data});
        end
    end

    // Monitor: compare outputs mid-cycle against the model and scoreboard.
    always @(negedge clk) begin
        if (armed) begin
            bit   exp_en;
            exp_t e;
            exp_en = 1'b0;
            if (sb.size() > 0) begin
                if (sb[0].cyc == cyc) exp_en = 1'b1;
            end
            chk("wr_en", {63'd0, wr_en}, {63'd0, exp_en});
            if (exp_en) begin
                e = sb.pop_front();
                if (wr_en) begin
                    chk("wr_rd", {59'd0, wr_rd}, {59'd0, e.rd});
                    chk("wr_data", wr_data, e.data);
                end
            end
            chk("a_ready", {63'd0, a_ready}, {63'd0, (!reset && qa.size() < DEPTH)});
            chk("m_ready", {63'd0, m_ready}, {63'd0, (!reset && qm.size() < DEPTH)});
            chk("idle", {63'd0, idle}, {63'd0, (qa.size() == 0 && qm.size() == 0 && !mwr_en)});
            chk("conflicts", {62'd0, conflicts}, DATA_W'(mconf));
        end
    end

    task automatic step(input bit rst, input bit av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] ad,
                        input bit mv, input logic [ADDR_W-1:0] mrd, input logic [DATA_W-1:0] md);
        reset   = rst;
        a_valid = av;
        a_rd    = ard;
        a_data  = ad;
        m_valid = mv;
        m_rd    = mrd;
        m_data  = md;
        @(negedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    endtask

    initial begin
        int ia;
        int im;
        bit acc_a;
        bit acc_m;
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        do_reset();

        // Single ALU write
        step(1'b0, 1'b1, 5'd5, 64'hAA, 1'b0, 5'd0, 64'd0);
        idle_cycles(4);

        // Simultaneous A and M push
        step(1'b0, 1'b1, 5'd3, 64'h11, 1'b1, 5'd4, 64'h22);
        idle_cycles(4);

        // Sustained contention, four entries per side
        do_reset();
        ia = 0;
        im = 0;
        for (int c = 0; c < 20; c++) begin
            reset   = 1'b0;
            a_valid = (ia < 4);
            a_rd    = ADDR_W'(8 + ia);
            a_data  = DATA_W'(8'hA0 + ia);
            m_valid = (im < 4);
            m_rd    = ADDR_W'(16 + im);
            m_data  = DATA_W'(8'hB0 + im);
            #1;
            acc_a = a_valid && a_ready;
            acc_m = m_valid && m_ready;
            @(negedge clk);
            #1;
            if (acc_a) ia++;
            if (acc_m) im++;
        end
        idle_cycles(3);

        // Load to x0 is consumed silently
        step(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'h55);
        idle_cycles(4);

        // Fill A under contention, then reset with a_valid held
        for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 5'd7, DATA_W'(c + 1), 1'b1, 5'd9, DATA_W'(c + 16));
        step(1'b1, 1'b1, 5'd7, 64'hDEAD, 1'b0, 5'd0, 64'd0);
        idle_cycles(5);

        // Counter saturation: keep both queues busy
        for (int c = 0; c < 8; c++) step(1'b0, 1'b1, 5'd1, DATA_W'(c), 1'b1, 5'd2, DATA_W'(c + 100));
        idle_cycles(5);

        // Randomised traffic with rare resets
        for (int c = 0; c < 1500; c++) begin
            step(($urandom_range(0, 99) < 1),
                 ($urandom_range(0, 99) < 60), ADDR_W'($urandom_range(0, 31)), {$urandom, $urandom},
                 ($urandom_range(0, 99) < 60), ADDR_W'($urandom_range(0, 31)), {$urandom, $urandom});
        end
        idle_cycles(8);
        chk("drained", DATA_W'(sb.size() + qa.size() + qm.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
